// File: rtl/optical_switch_driver.sv
// Serial driver for the 2x2 switch-element shift register of the 8x8 optical
// switch. It takes a grant word and shifts it out MSB first, then latches it
// and waits the optical settle time before reporting completion. A one-deep
// pending buffer holds the newest grant that arrives while a configuration is
// already running.
module optical_switch_driver #(
  parameter int P_GRANTWIDTH = 20,
  parameter int P_CLKDIV     = 4,
  parameter int P_SETTLE     = 64
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [P_GRANTWIDTH-1:0] i_grant,
  input  logic                    i_grant_valid,
  output logic                    o_sclk,
  output logic                    o_sdata,
  output logic                    o_latch,
  output logic                    o_busy,
  output logic                    o_config_done,
  output logic [P_GRANTWIDTH-1:0] o_switch_state,
  output logic                    o_overflow
);

  // One counter serves three purposes: the serial-clock phase in SHIFT, the
  // latch width in LATCH and the settle wait in SETTLE. It is sized for the
  // longest of these.
  localparam int LP_CNTMAX = (2 * P_CLKDIV > P_SETTLE) ? 2 * P_CLKDIV : P_SETTLE;
  localparam int LP_CW     = $clog2(LP_CNTMAX + 1);
  localparam int LP_BW     = $clog2(P_GRANTWIDTH + 1);

  localparam logic [LP_CW-1:0] LP_PH_LAST     = LP_CW'(2 * P_CLKDIV - 1);
  localparam logic [LP_CW-1:0] LP_SCLK_HI     = LP_CW'(P_CLKDIV);
  localparam logic [LP_CW-1:0] LP_LATCH_LAST  = LP_CW'(P_CLKDIV - 1);
  localparam logic [LP_CW-1:0] LP_SETTLE_LAST = LP_CW'(P_SETTLE - 1);
  localparam logic [LP_BW-1:0] LP_BIT_LAST    = LP_BW'(P_GRANTWIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_LATCH,
    S_SETTLE,
    S_DONE
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [LP_CW-1:0]        r_cnt;
  logic [LP_BW-1:0]        r_bit;
  logic [P_GRANTWIDTH-1:0] r_shift;
  logic [P_GRANTWIDTH-1:0] r_word;
  logic [P_GRANTWIDTH-1:0] r_pend;
  logic                    r_pend_full;
  logic [P_GRANTWIDTH-1:0] r_switch;

  logic                    w_bit_end;
  logic                    w_load;
  logic [P_GRANTWIDTH-1:0] w_load_word;

  assign w_bit_end = (r_cnt == LP_PH_LAST);

  // A new configuration starts either from IDLE on a valid, or straight out
  // of DONE when a word is waiting (pending or arriving in that very cycle).
  assign w_load = ((r_state == S_IDLE) && i_grant_valid) ||
                  ((r_state == S_DONE) && (r_pend_full || i_grant_valid));
  // In DONE the pending word is older than a coincident valid, so it goes
  // first and the coincident valid takes its place in the buffer.
  assign w_load_word = ((r_state == S_DONE) && r_pend_full) ? r_pend : i_grant;

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (i_grant_valid) w_next = S_SHIFT;
      S_SHIFT:  if (w_bit_end && (r_bit == LP_BIT_LAST)) w_next = S_LATCH;
      S_LATCH:  if (r_cnt == LP_LATCH_LAST) w_next = S_SETTLE;
      S_SETTLE: if (r_cnt == LP_SETTLE_LAST) w_next = S_DONE;
      S_DONE:   w_next = (r_pend_full || i_grant_valid) ? S_SHIFT : S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Moore outputs from state and counters; overflow reacts to the input strobe.
  always_comb begin
    o_sclk        = 1'b0;
    o_sdata       = 1'b0;
    o_latch       = 1'b0;
    o_config_done = 1'b0;
    o_busy        = (r_state != S_IDLE);
    o_overflow    = i_grant_valid && r_pend_full &&
                    (r_state inside {S_SHIFT, S_LATCH, S_SETTLE});
    case (r_state)
      S_SHIFT: begin
        o_sclk  = (r_cnt >= LP_SCLK_HI);
        o_sdata = r_shift[P_GRANTWIDTH-1];
      end
      S_LATCH: o_latch = 1'b1;
      S_DONE:  o_config_done = 1'b1;
      default: ;
    endcase
  end

  // Phase/bit counters; restart on every state change and at each bit boundary.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_bit <= '0;
    end else if (w_next != r_state) begin
      r_cnt <= '0;
      r_bit <= '0;
    end else if ((r_state == S_SHIFT) && w_bit_end) begin
      r_cnt <= '0;
      r_bit <= r_bit + 1'b1;
    end else if (r_state != S_IDLE) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Serial shift register and the copy of the word being applied; the shift
  // happens at the end of each bit window so o_sdata changes while o_sclk is low.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shift <= '0;
      r_word  <= '0;
    end else if (w_load) begin
      r_shift <= w_load_word;
      r_word  <= w_load_word;
    end else if ((r_state == S_SHIFT) && w_bit_end) begin
      r_shift <= {r_shift[P_GRANTWIDTH-2:0], 1'b0};
    end
  end

  // Pending buffer: newest grant received while busy wins.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pend      <= '0;
      r_pend_full <= 1'b0;
    end else if (r_state == S_DONE) begin
      if (r_pend_full && i_grant_valid) r_pend <= i_grant;
      else if (r_pend_full)             r_pend_full <= 1'b0;
    end else if ((r_state != S_IDLE) && i_grant_valid) begin
      r_pend      <= i_grant;
      r_pend_full <= 1'b1;
    end
  end

  // Applied switch state becomes visible together with the DONE pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                                           r_switch <= '0;
    else if ((r_state == S_SETTLE) && (w_next == S_DONE)) r_switch <= r_word;
  end

  assign o_switch_state = r_switch;

endmodule

// File: tb/tb_optical_switch_driver.sv
// Bench for optical_switch_driver: a default instance and a fast variant
// (P_CLKDIV = 1, P_SETTLE = 1) driven side by side. A timeline model predicts
// when each configuration completes and which word it applies.
module tb_optical_switch_driver;
  localparam int W = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int kdiv[2]   = '{4, 1};
  int settle[2] = '{64, 1};
  int lat[2]    = '{229, 43};

  logic         rst[2];
  logic [W-1:0] grant[2];
  logic         gv[2];
  logic         sclk[2], sdata[2], latch[2], busy[2], done[2], ovf[2];
  logic [W-1:0] sw[2];

  optical_switch_driver u_dut0 (
    .i_clk(clk), .i_rst(rst[0]), .i_grant(grant[0]), .i_grant_valid(gv[0]),
    .o_sclk(sclk[0]), .o_sdata(sdata[0]), .o_latch(latch[0]), .o_busy(busy[0]),
    .o_config_done(done[0]), .o_switch_state(sw[0]), .o_overflow(ovf[0])
  );

  optical_switch_driver #(.P_GRANTWIDTH(20), .P_CLKDIV(1), .P_SETTLE(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst[1]), .i_grant(grant[1]), .i_grant_valid(gv[1]),
    .o_sclk(sclk[1]), .o_sdata(sdata[1]), .o_latch(latch[1]), .o_busy(busy[1]),
    .o_config_done(done[1]), .o_switch_state(sw[1]), .o_overflow(ovf[1])
  );

  int checks = 0;
  int errors = 0;

  typedef struct {int t; logic [W-1:0] w;} exp_t;
  exp_t exp_q0[$], exp_q1[$];
  int   ovf_q0[$], ovf_q1[$];

  // Timeline model state per instance
  bit           m_active[2];
  int           m_start[2], m_done[2];
  logic [W-1:0] m_cur[2], m_pend_w[2], m_sw[2];
  bit           m_pend_v[2];
  bit           exp_busy[2];

  // Monitor state per instance
  bit           p_sclk[2], p_sdata[2];
  logic [W-1:0] recon[2];
  int           nbits[2], latch_cnt[2], latch_first[2];

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, expv);
    end
  endtask

  task automatic push_exp(int d, int t, logic [W-1:0] w);
    exp_t e;
    e.t = t; e.w = w;
    if (d == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
  endtask

  task automatic start_app(int d, int t, logic [W-1:0] w);
    m_active[d] = 1'b1;
    m_start[d]  = t;
    m_done[d]   = t + lat[d];
    m_cur[d]    = w;
    push_exp(d, m_done[d], w);
  endtask

  // Advance the model by one cycle t with this cycle's inputs.
  task automatic model_step(int d, bit r, bit v, logic [W-1:0] w);
    int t = cyc;
    if (r) begin
      m_active[d] = 0; m_pend_v[d] = 0; m_sw[d] = '0; exp_busy[d] = 0;
      if (d == 0) begin exp_q0.delete(); ovf_q0.delete(); end
      else        begin exp_q1.delete(); ovf_q1.delete(); end
      return;
    end
    exp_busy[d] = m_active[d] && (t > m_start[d]) && (t <= m_done[d]);
    if (m_active[d] && t == m_done[d]) begin
      m_sw[d] = m_cur[d];
      if (m_pend_v[d]) begin
        start_app(d, t, m_pend_w[d]);
        m_pend_v[d] = v;
        if (v) m_pend_w[d] = w;
      end else if (v) start_app(d, t, w);
      else m_active[d] = 0;
    end else if (exp_busy[d]) begin
      if (v) begin
        if (m_pend_v[d]) begin
          if (d == 0) ovf_q0.push_back(t); else ovf_q1.push_back(t);
        end
        m_pend_v[d] = 1; m_pend_w[d] = w;
      end
    end else if (v) start_app(d, t, w);
  endtask

  task automatic step(bit v0, logic [W-1:0] w0, bit v1, logic [W-1:0] w1, bit r0, bit r1);
    @(negedge clk);
    gv[0] = v0; grant[0] = v0 ? w0 : W'($urandom);
    gv[1] = v1; grant[1] = v1 ? w1 : W'($urandom);
    rst[0] = r0; rst[1] = r1;
    model_step(0, r0, v0, w0);
    model_step(1, r1, v1, w1);
  endtask

  task automatic idle(int n);
    repeat (n) step(0, '0, 0, '0, 0, 0);
  endtask

  task automatic send0(logic [W-1:0] w);
    step(1, w, 0, '0, 0, 0);
  endtask

  task automatic mon(int d);
    exp_t e;
    int   ot;
    bit   have;
    if (rst[d]) begin
      chk($sformatf("dut%0d outputs in reset", d),
          32'({sclk[d], sdata[d], latch[d], busy[d], done[d], ovf[d], sw[d]}), 32'd0);
      recon[d] = '0; nbits[d] = 0; latch_cnt[d] = 0; latch_first[d] = -1;
      p_sclk[d] = 0; p_sdata[d] = 0;
      return;
    end
    chk($sformatf("dut%0d busy", d), 32'(busy[d]), 32'(exp_busy[d]));
    chk($sformatf("dut%0d switch_state", d), 32'(sw[d]), 32'(m_sw[d]));
    if (p_sclk[d] && sclk[d])
      chk($sformatf("dut%0d sdata stable while sclk high", d), 32'(sdata[d]), 32'(p_sdata[d]));
    if (!p_sclk[d] && sclk[d]) begin
      recon[d] = {recon[d][W-2:0], sdata[d]};
      nbits[d]++;
    end
    if (latch[d]) begin
      if (latch_cnt[d] == 0) latch_first[d] = cyc;
      latch_cnt[d]++;
    end
    // overflow scoreboard
    if (d == 0) while (ovf_q0.size() > 0 && ovf_q0[0] < cyc) begin
      ot = ovf_q0.pop_front(); chk("dut0 missing overflow", 32'(cyc), 32'(ot));
    end
    if (d == 1) while (ovf_q1.size() > 0 && ovf_q1[0] < cyc) begin
      ot = ovf_q1.pop_front(); chk("dut1 missing overflow", 32'(cyc), 32'(ot));
    end
    if (ovf[d]) begin
      have = (d == 0) ? (ovf_q0.size() > 0) : (ovf_q1.size() > 0);
      if (!have) chk($sformatf("dut%0d unexpected overflow", d), 32'(ovf[d]), 32'd0);
      else begin
        ot = (d == 0) ? ovf_q0.pop_front() : ovf_q1.pop_front();
        chk($sformatf("dut%0d overflow cycle", d), 32'(cyc), 32'(ot));
      end
    end
    // completion scoreboard
    if (d == 0) while (exp_q0.size() > 0 && exp_q0[0].t < cyc) begin
      e = exp_q0.pop_front(); chk("dut0 missing config_done", 32'(cyc), 32'(e.t));
    end
    if (d == 1) while (exp_q1.size() > 0 && exp_q1[0].t < cyc) begin
      e = exp_q1.pop_front(); chk("dut1 missing config_done", 32'(cyc), 32'(e.t));
    end
    if (done[d]) begin
      have = (d == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
      if (!have) chk($sformatf("dut%0d unexpected config_done", d), 32'(done[d]), 32'd0);
      else begin
        e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        chk($sformatf("dut%0d done cycle", d), 32'(cyc), 32'(e.t));
        chk($sformatf("dut%0d applied word", d), 32'(sw[d]), 32'(e.w));
        chk($sformatf("dut%0d serial word", d), 32'(recon[d]), 32'(e.w));
        chk($sformatf("dut%0d serial bit count", d), 32'(nbits[d]), 32'(W));
        chk($sformatf("dut%0d latch width", d), 32'(latch_cnt[d]), 32'(kdiv[d]));
        chk($sformatf("dut%0d latch start", d), 32'(latch_first[d]),
            32'(e.t - settle[d] - kdiv[d]));
      end
      recon[d] = '0; nbits[d] = 0; latch_cnt[d] = 0; latch_first[d] = -1;
    end
    p_sclk[d]  = sclk[d];
    p_sdata[d] = sdata[d];
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #1;
      for (int d = 0; d < 2; d++) mon(d);
    end
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1; gv[d] = 0; grant[d] = '0;
      m_active[d] = 0; m_pend_v[d] = 0; m_sw[d] = '0; exp_busy[d] = 0;
      p_sclk[d] = 0; p_sdata[d] = 0; recon[d] = '0; nbits[d] = 0;
      latch_cnt[d] = 0; latch_first[d] = -1;
    end
    repeat (3) step(0, '0, 0, '0, 1, 1);
    idle(2);
    // single configuration
    send0(20'hA5C3F); idle(259);
    // back-to-back, second valid 50 cycles later
    send0(20'h00001); idle(49); send0(20'hFFFFF); idle(480);
    // pending overwrite
    send0(20'h11111); idle(9); send0(20'h22222); idle(9); send0(20'h33333); idle(480);
    // valid coincident with DONE
    send0(20'h0F0F0); idle(228); send0(20'hF0F0F); idle(480);
    // reset in the middle of a shift, then a normal configuration
    send0(20'h12345); idle(79);
    repeat (3) step(0, '0, 0, '0, 1, 0);
    idle(5);
    send0(20'h5A5A5); idle(260);
    // fast variant, single configuration
    step(0, '0, 1, 20'hABCDE, 0, 0); idle(60);
    // randomized traffic on both instances
    repeat (6000) begin
      step(($urandom_range(0, 149) == 0), W'($urandom),
           ($urandom_range(0, 29) == 0), W'($urandom), 0, 0);
    end
    idle(600);
    chk("dut0 expected completions left", 32'(exp_q0.size()), 32'd0);
    chk("dut1 expected completions left", 32'(exp_q1.size()), 32'd0);
    chk("dut0 expected overflows left", 32'(ovf_q0.size()), 32'd0);
    chk("dut1 expected overflows left", 32'(ovf_q1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/optical_switch_driver.md
Name: optical_switch_driver

Overview:
- Downstream stage of the 8x8 optical switch controller.
- Consumes the 20-bit combined grant word and its valid strobe:
  - [19:16] 8x8 output stage
  - [15:12] 8x8 input stage
  - [11:6] 4x4 sub-switch 2
  - [5:0] 4x4 sub-switch 1
- Shifts the word serially into the external 2x2-element driver shift register, latches it, waits the optical settle time, then reports completion.
- Holds a one-deep pending buffer so a grant arriving mid-configuration is not lost.

Parameters:
- P_GRANTWIDTH, 20, number of 2x2 switch elements (grant bits); each bit is 0 = BAR, 1 = CROSS.
- P_CLKDIV, 4, i_clk cycles per serial-clock half-period; must be >= 1.
- P_SETTLE, 64, i_clk cycles of optical settle wait after latch; must be >= 1.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset
- i_grant  in  P_GRANTWIDTH  combined grant word
- i_grant_valid  in  1  single-cycle strobe qualifying i_grant
- o_sclk  out  1  serial clock to driver shift register; data sampled on rising edge
- o_sdata  out  1  serial data, MSB (bit 19) first
- o_latch  out  1  load strobe to driver output register
- o_busy  out  1  configuration in progress
- o_config_done  out  1  one-cycle pulse; new state applied and settled
- o_switch_state  out  P_GRANTWIDTH  last fully applied grant word
- o_overflow  out  1  one-cycle pulse; pending buffer overwritten

Behaviour:
- Reset: i_rst is asynchronous, active-high; the clock is i_clk. Reset forces all outputs to 0 (o_switch_state = all BAR), FSM to IDLE, pending buffer empty, and counters to 0. Reset mid-operation aborts immediately; the partial shift is discarded and no o_latch or o_config_done is issued.
- FSM states: IDLE, SHIFT, LATCH, SETTLE, DONE.
- IDLE:
  - o_busy = 0.
  - i_grant_valid seen at clock edge of cycle 0 captures i_grant into the shift register.
  - Cycle 1 enters SHIFT.
- SHIFT:
  - Each bit occupies 2*P_CLKDIV cycles: o_sclk low for P_CLKDIV cycles, then high for P_CLKDIV cycles.
  - o_sdata holds the bit for the full 2*P_CLKDIV window and changes only while o_sclk is low.
  - Bit order is 19 down to 0.
  - With defaults, cycles 1..160.
- LATCH:
  - o_sclk = 0; o_latch = 1 for P_CLKDIV cycles (cycles 161..164).
  - o_sdata returns to 0.
- SETTLE: all serial outputs are 0 for P_SETTLE cycles (cycles 165..228).
- DONE (one cycle, cycle 229):
  - o_config_done = 1.
  - o_switch_state updates to the applied word in the same cycle.
  - Next state is SHIFT if the pending buffer is full (buffer is consumed; first shift cycle is 230); otherwise IDLE.
- o_busy = 1 in SHIFT, LATCH, SETTLE and DONE.
- Default latency from valid to o_config_done is 229 cycles. General formula: 1 + 2*P_CLKDIV*P_GRANTWIDTH + P_CLKDIV + P_SETTLE.
- Pending buffer:
  - i_grant_valid while o_busy = 1, including the DONE cycle, stores into pending.
  - If pending is already full, the new word overwrites it and o_overflow pulses in that cycle.
  - Only the newest pending word is ever applied.
- Valid in the DONE cycle with an empty pending buffer: stored to pending, then shifted from cycle 230; o_busy does not drop.
- There is no skip-if-equal: an identical word is re-applied with full timing.
- i_grant is ignored when i_grant_valid = 0.

Test Plan:
- Single config: i_grant = 20'hA5C3F, one valid pulse in IDLE → bench samples on o_sclk rising edges and reconstructs 20'hA5C3F MSB first. Required timing:
  - o_latch high cycles 161..164.
  - o_config_done pulse at cycle 229.
  - o_switch_state = 20'hA5C3F from cycle 229.
  - o_busy low at 230.
- Back-to-back: 20'h00001, then 20'hFFFFF at cycle 50 → first done at 229; second shift starts at 230 with o_busy continuously high; second done at 458; o_switch_state = 20'hFFFFF; no o_overflow.
- Overflow: valids 20'h11111 (cycle 0), 20'h22222 (cycle 10), 20'h33333 (cycle 20) → o_overflow pulse at cycle 20 only; second applied word is 20'h33333; 20'h22222 never appears on o_sdata.
- Valid coincident with DONE: 20'h0F0F0 at cycle 0, 20'hF0F0F at cycle 229 → second shift starts at 230; done at 458; o_busy never deasserts.
- Reset mid-shift: assert i_rst at cycle 80 for 3 cycles → all outputs 0 asynchronously, including o_switch_state = 0; no o_latch or o_config_done; a following valid with 20'h5A5A5 completes normally after 229 cycles.
- Parameter variant: P_CLKDIV = 1, P_SETTLE = 1 → o_sclk toggles every cycle; o_config_done at cycle 43 after valid.
